// File: rtl/score_flow_controller_pkg.sv
// rtl/score_flow_controller_pkg.sv - shared state encoding and score width for the score flow controller
package score_flow_controller_pkg;

    localparam int SCORE_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAYING   = 2'd1,
        COMMIT    = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

endpackage

// File: rtl/score_flow_controller_if.sv
// rtl/score_flow_controller_if.sv - gameplay/display signal bundle for the score flow controller
interface score_flow_controller_if #(
    parameter int SCORE_W = score_flow_controller_pkg::SCORE_W_DEFAULT
);
    logic               start_req;
    logic               hs_clear;
    logic               hit;
    logic               life_lost;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] highscore;
    logic [2:0]         lives;
    logic               game_active;
    logic               game_over;
    logic               new_record;

    // Gameplay/display side: drives the pulses, reads the score outputs.
    modport master (
        output start_req, hs_clear, hit, life_lost,
        input  score, highscore, lives, game_active, game_over, new_record
    );

    // Controller side.
    modport slave (
        input  start_req, hs_clear, hit, life_lost,
        output score, highscore, lives, game_active, game_over, new_record
    );
endinterface

// File: rtl/score_flow_controller_sat_accumulator.sv
// rtl/score_flow_controller_sat_accumulator.sv - saturating score accumulator with sync clear
module sat_accumulator #(
    parameter int W    = 8,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] value
);
    localparam logic [W:0] MAX_EXT  = {1'b0, {W{1'b1}}};
    localparam logic [W:0] STEP_EXT = (W+1)'(STEP);

    // One extra bit of headroom so an overflow is seen and clamped instead of wrapping.
    logic [W:0] sum;
    assign sum = {1'b0, value} + STEP_EXT;

    // Clear has priority over accumulate; add clamps to all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (en) begin
            value <= (sum > MAX_EXT) ? MAX_EXT[W-1:0] : sum[W-1:0];
        end
    end
endmodule

// File: rtl/score_flow_controller.sv
// rtl/score_flow_controller.sv - game session sequencer owning score, lives and high score
module score_flow_controller
    import score_flow_controller_pkg::*;
#(
    parameter int SCORE_W          = SCORE_W_DEFAULT,
    parameter int LIVES            = 3,
    parameter int HIT_POINTS       = 1,
    parameter int OVER_HOLD_CYCLES = 50_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    score_flow_controller_if.slave  bus
);
    localparam int              HOLD_W    = (OVER_HOLD_CYCLES > 1) ? $clog2(OVER_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(OVER_HOLD_CYCLES - 1);
    localparam logic [2:0]      LIVES_INIT = 3'(LIVES);

    state_t             state, state_next;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] highscore_q;
    logic [2:0]         lives_q;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               active_q, over_q, record_q;

    logic start_go, hit_go, life_go, fatal_hit;
    assign start_go  = (state == IDLE) && bus.start_req;
    assign hit_go    = (state == PLAYING) && bus.hit;
    assign life_go   = (state == PLAYING) && bus.life_lost;
    assign fatal_hit = life_go && (lives_q == 3'd1);

    sat_accumulator #(.W(SCORE_W), .STEP(HIT_POINTS)) u_score (
        .clk   (clk),
        .reset (reset),
        .clear (start_go),
        .en    (hit_go),
        .value (score_q)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; COMMIT always lasts exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (bus.start_req) state_next = PLAYING;
            PLAYING:   if (fatal_hit) state_next = COMMIT;
            COMMIT:    state_next = GAME_OVER;
            GAME_OVER: if (hold_cnt == HOLD_LAST) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Lives, hold timer, high-score commit and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lives_q     <= '0;
            hold_cnt    <= '0;
            highscore_q <= '0;
            record_q    <= 1'b0;
            active_q    <= 1'b0;
            over_q      <= 1'b0;
        end else begin
            active_q <= (state_next == PLAYING);
            over_q   <= (state_next == GAME_OVER);
            case (state)
                IDLE: begin
                    if (bus.start_req) begin
                        lives_q  <= LIVES_INIT;
                        record_q <= 1'b0;
                    end else if (bus.hs_clear) begin
                        highscore_q <= '0;
                    end
                end
                PLAYING: begin
                    if (life_go) lives_q <= lives_q - 3'd1;
                end
                COMMIT: begin
                    hold_cnt <= '0;
                    if (score_q > highscore_q) begin
                        highscore_q <= score_q;
                        record_q    <= 1'b1;
                    end else begin
                        record_q    <= 1'b0;
                    end
                end
                GAME_OVER: begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.score       = score_q;
    assign bus.highscore   = highscore_q;
    assign bus.lives       = lives_q;
    assign bus.game_active = active_q;
    assign bus.game_over   = over_q;
    assign bus.new_record  = record_q;
endmodule

// File: tb/tb_score_flow_controller.sv
// tb/tb_score_flow_controller.sv - directed self-checking bench for score_flow_controller
module tb_score_flow_controller;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    score_flow_controller_if #(.SCORE_W(8)) a_if ();
    score_flow_controller_if #(.SCORE_W(8)) b_if ();

    score_flow_controller #(
        .SCORE_W(8), .LIVES(3), .HIT_POINTS(1), .OVER_HOLD_CYCLES(4)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if)
    );

    score_flow_controller #(
        .SCORE_W(8), .LIVES(3), .HIT_POINTS(100), .OVER_HOLD_CYCLES(4)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given pulses on dut_a, sampled 1 time unit after the edge.
    task automatic step(input logic s, input logic hc, input logic h, input logic l);
        a_if.start_req = s;
        a_if.hs_clear  = hc;
        a_if.hit       = h;
        a_if.life_lost = l;
        @(posedge clk);
        #1;
        a_if.start_req = 1'b0;
        a_if.hs_clear  = 1'b0;
        a_if.hit       = 1'b0;
        a_if.life_lost = 1'b0;
    endtask

    task automatic b_step(input logic s, input logic h);
        b_if.start_req = s;
        b_if.hit       = h;
        @(posedge clk);
        #1;
        b_if.start_req = 1'b0;
        b_if.hit       = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        a_if.start_req = 0; a_if.hs_clear = 0; a_if.hit = 0; a_if.life_lost = 0;
        b_if.start_req = 0; b_if.hs_clear = 0; b_if.hit = 0; b_if.life_lost = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_score",  a_if.score, 0);
        check("rst_hs",     a_if.highscore, 0);
        check("rst_lives",  a_if.lives, 0);
        check("rst_active", a_if.game_active, 0);
        check("rst_over",   a_if.game_over, 0);
        check("rst_record", a_if.new_record, 0);
        reset = 1'b0;

        // Saturation on the HIT_POINTS=100 instance.
        b_step(1, 0);
        b_step(0, 1); check("sat_1", b_if.score, 100);
        b_step(0, 1); check("sat_2", b_if.score, 200);
        b_step(0, 1); check("sat_3", b_if.score, 255);
        b_step(0, 1); check("sat_4", b_if.score, 255);

        // Gameplay pulses in IDLE are ignored.
        step(0, 0, 1, 1);
        check("idle_hit_score", a_if.score, 0);
        check("idle_hit_lives", a_if.lives, 0);

        // Round 1: 5 hits -> record 5.
        step(1, 0, 0, 0);
        check("r1_active", a_if.game_active, 1);
        check("r1_lives0", a_if.lives, 3);
        check("r1_score0", a_if.score, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        check("r1_score", a_if.score, 5);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("r1_lives1", a_if.lives, 1);
        step(0, 0, 0, 1);
        check("r1_commit_active", a_if.game_active, 0);
        check("r1_commit_over",   a_if.game_over, 0);
        check("r1_commit_lives",  a_if.lives, 0);
        check("r1_commit_hs",     a_if.highscore, 0);
        step(0, 0, 0, 0);
        check("r1_hs",     a_if.highscore, 5);
        check("r1_record", a_if.new_record, 1);
        check("r1_over1",  a_if.game_over, 1);
        step(0, 0, 1, 1);
        check("go_hit_score", a_if.score, 5);
        check("go_hit_lives", a_if.lives, 0);
        check("r1_over2",     a_if.game_over, 1);
        step(0, 1, 0, 0);
        check("go_hsclr", a_if.highscore, 5);
        check("r1_over3", a_if.game_over, 1);
        step(0, 0, 0, 0);
        check("r1_over4", a_if.game_over, 1);
        step(0, 0, 0, 0);
        check("r1_idle_over",   a_if.game_over, 0);
        check("r1_idle_record", a_if.new_record, 1);
        check("r1_idle_score",  a_if.score, 5);

        // Round 2: 3 hits, lower score; hs_clear while playing is ignored.
        step(1, 0, 0, 0);
        check("r2_record_clr", a_if.new_record, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        check("play_hsclr", a_if.highscore, 5);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("r2_hs",     a_if.highscore, 5);
        check("r2_record", a_if.new_record, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        check("r2_idle", a_if.game_over, 0);

        // Round 3: equal score is not a record.
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("r3_hs",     a_if.highscore, 5);
        check("r3_record", a_if.new_record, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

        // Round 4: fatal life_lost with a hit at score 9 commits 10.
        step(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        check("r4_commit_score", a_if.score, 10);
        step(0, 0, 0, 0);
        check("r4_hs",     a_if.highscore, 10);
        check("r4_record", a_if.new_record, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

        // start_req with hs_clear in IDLE: start wins.
        step(1, 1, 0, 0);
        check("both_active", a_if.game_active, 1);
        check("both_hs",     a_if.highscore, 10);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("r5_hs", a_if.highscore, 10);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

        // hs_clear alone in IDLE.
        step(0, 1, 0, 0);
        check("idle_hsclr", a_if.highscore, 0);

        // Asynchronous reset during PLAYING.
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        reset = 1'b1;
        #1;
        check("rst_play_score",  a_if.score, 0);
        check("rst_play_lives",  a_if.lives, 0);
        check("rst_play_active", a_if.game_active, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset during the COMMIT cycle drops the commit.
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        reset = 1'b1;
        #1;
        check("rst_commit_score", a_if.score, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(0, 0, 0, 0);
        check("rst_commit_hs",     a_if.highscore, 0);
        check("rst_commit_record", a_if.new_record, 0);
        check("rst_commit_over",   a_if.game_over, 0);
        check("rst_commit_active", a_if.game_active, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
